// File: rtl/seq_const_lohi_pkg.sv
// Shared types and constants for the constant lo/hi line sequencer.
package seq_const_lohi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/seq_const_lohi_dly_cnt.sv
// Loadable dwell down-counter; saturates at zero so a maximum dwell never wraps.
module seq_const_lohi_dly_cnt #(
  parameter int DLYW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [DLYW-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [DLYW-1:0] cnt_q;
  logic [DLYW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - DLYW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_const_lohi_ctrl.sv
// Steps a bank of tie-off lines to all-hi (LSB first) or all-lo (MSB first),
// one line per dwell period, behind a valid/ready request handshake.
module seq_const_lohi_ctrl
  import seq_const_lohi_pkg::*;
#(
  parameter int NBITS = 4,
  parameter int DLYW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_val,
  output logic             cfg_rdy,
  input  logic             cfg_dir,
  input  logic [DLYW-1:0]  cfg_dly,
  input  logic             abort,
  output logic [NBITS-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  state_t          state_q;
  logic            dir_q;
  logic [DLYW-1:0] dly_q;
  logic [IW-1:0]   idx_q;
  logic [NBITS-1:0] out_q;

  logic            cnt_zero;
  logic            cnt_load;
  logic            cnt_dec;
  logic [DLYW-1:0] cnt_load_val;
  logic [IW-1:0]   last_idx;
  logic            step;
  logic            accept;

  assign accept   = (state_q == IDLE) && cfg_val;
  assign step     = (state_q == WAIT) && !abort && cnt_zero;
  assign last_idx = (dir_q == DIR_UP) ? IW'(NBITS - 1) : '0;

  // The counter reloads both on acceptance and between steps; abort freezes it.
  assign cnt_load     = accept || (step && (idx_q != last_idx));
  assign cnt_load_val = accept ? cfg_dly : dly_q;
  assign cnt_dec      = (state_q == WAIT) && !abort && !cnt_zero;

  seq_const_lohi_dly_cnt #(
    .DLYW(DLYW)
  ) u_dly_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_DOWN;
      dly_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_val) begin
            dir_q   <= cfg_dir;
            dly_q   <= cfg_dly;
            idx_q   <= (cfg_dir == DIR_UP) ? '0 : IW'(NBITS - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (cnt_zero) begin
            out_q[idx_q] <= dir_q;
            if (idx_q == last_idx) begin
              state_q <= DONE;
            end else if (dir_q == DIR_UP) begin
              idx_q <= idx_q + IW'(1);
            end else begin
              idx_q <= idx_q - IW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign cfg_rdy = (state_q == IDLE);
  assign busy    = (state_q == WAIT);
  assign done    = (state_q == DONE);

endmodule

// File: doc/seq_const_lohi_ctrl.md
Name: seq_const_lohi_ctrl

Overview:
- Sequencer that steps a bank of constant tie-off lines between all-lo (0) and all-hi (1), one line at a time, with a programmable dwell between steps.
- Sits in front of constant lo/hi driver cells that feed straps and enables. It orders power-up (assert LSB first) and power-down (deassert MSB first) so that downstream blocks never see simultaneous edges.
- A request is accepted over a valid/ready config handshake. The block reports progress on busy and pulses done on completion.

Parameters:
- NBITS, 4, number of sequenced output lines (>=1)
- DLYW, 4, width of the dwell-count field

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- cfg_val  input  1  request valid
- cfg_rdy  output  1  block can accept a request
- cfg_dir  input  1  target level: 1 = drive all lines hi (up), 0 = drive all lines lo (down)
- cfg_dly  input  DLYW  dwell d; each step takes d+1 cycles
- abort  input  1  cancel an in-progress sequence
- out  output  NBITS  sequenced lo/hi lines, registered
- busy  output  1  sequence in progress
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset (reset==0): asynchronously forces state=IDLE, out=0, cnt=0, idx=0, busy=0, done=0, cfg_rdy=1. Reset mid-sequence drops out to all-zero immediately, without waiting for a clock edge. No request survives reset.
- States: IDLE, WAIT, DONE. cfg_rdy=(state==IDLE). busy=(state==WAIT). done=(state==DONE). All three are decoded from state only.
- IDLE: handshake = cfg_val && cfg_rdy. On handshake, latch dir=cfg_dir and dly=cfg_dly, set cnt=cfg_dly, and go to WAIT. idx starts at 0 for up and NBITS-1 for down.
- WAIT, abort=1: go to IDLE. out holds its partial value, the current bit is not written, and done does not pulse. Abort wins over a step in the same cycle. abort is ignored outside WAIT.
- WAIT, cnt!=0: decrement cnt.
- WAIT, cnt==0: out[idx] <= dir.
  - If idx is the last bit (NBITS-1 for up, 0 for down): go to DONE.
  - Otherwise: idx steps by +1 (up) or -1 (down), and cnt reloads from dly.
- DONE: lasts one cycle, then unconditionally goes to IDLE.
- Timing: handshake in cycle 0.
  - k-th step (k=0..NBITS-1) is visible on out in cycle (k+1)(d+1)+1.
  - done=1 in cycle NBITS(d+1)+1, the same cycle the last step is visible.
  - cfg_rdy=1 in the next cycle.
- Redundant request (e.g. up when out is already all ones) runs the full timed sequence. Writes are idempotent and done still pulses.
- cfg_val while cfg_rdy=0 is ignored and not queued. If cfg_val is held high through DONE, the request is accepted in the following IDLE cycle.
- Request after abort starts from the current partial out. Lines already at the target are rewritten harmlessly.
- d=max (2^DLYW-1): counter must not wrap. The step is taken exactly when cnt==0.
- cfg_dly and cfg_dir are sampled only on handshake. Later changes have no effect.

Decomposition:
- Package seq_const_lohi_pkg:
  - state enum (IDLE, WAIT, DONE)
  - DIR_UP=1, DIR_DOWN=0 constants
- Sub-module seq_const_lohi_dly_cnt: loadable DLYW-bit down counter with load, dec and zero outputs, async active-low reset.
- FSM, idx register and out register live in the top.

Test Plan (NBITS=4, DLYW=4; out shown MSB..LSB):
- Reset/idle: hold reset=0 for 2 cycles, then release and idle 3 cycles -> out=0000, cfg_rdy=1, busy=0, done=0 throughout.
- Up, d=0: handshake in cycle 0 -> out=0001 in c2, 0011 in c3, 0111 in c4, 1111 in c5; done=1 in c5 only; busy=1 in c1–c4; cfg_rdy=1 in c6.
- Up d=2 then down d=1:
  - Up: 1111 reached in c13 with done in c13.
  - Down, new handshake at c0': out=0111 at c3', 0011 at c5', 0001 at c7', 0000 at c9'; done at c9'.
- Abort: up with d=3 -> out=0001 in c5; abort=1 in c6 -> out stays 0001, busy=0 and cfg_rdy=1 in c7, done never pulses. A new up request with d=0 then ends at 1111.
- Handshake rules: pulse cfg_val mid-sequence -> ignored, sequence timing unchanged. Hold cfg_val=1 with cfg_dir=0 through DONE -> second request accepted in the first IDLE cycle after DONE.
- Async reset: drive reset=0 mid-cycle while out=0011 -> out=0000 and busy=0 before the next clk edge. After release, an up request with d=0 completes per the d=0 timing.
